// File: rtl/cpu_ask2_nios2_oci_dct_packer_if.sv
// Frame channel from the DCT packer toward the trace FIFO.
// Single-entry valid/ready handshake; a frame moves when frame_valid && frame_ready.
interface cpu_ask2_nios2_oci_dct_packer_if #(
    parameter int FRAME_W = 34
);
    logic               frame_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_ready;

    modport master (output frame_valid, output frame_data, input frame_ready);
    modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/cpu_ask2_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into a 30-bit DCT buffer and emits full or flushed
// buffers as {count, buffer} frames; atoms arriving while blocked are dropped.
module cpu_ask2_nios2_oci_dct_packer #(
    parameter int ATOM_W  = 2,
    parameter int DEPTH   = 15,
    parameter int COUNT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      trace_enable,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom,
    input  logic                      flush,
    output logic [ATOM_W*DEPTH-1:0]   dct_buffer,
    output logic [COUNT_W-1:0]        dct_count,
    output logic                      overflow,
    input  logic                      overflow_clr,
    cpu_ask2_nios2_oci_dct_packer_if.master frame_if
);
    localparam int BUF_W   = ATOM_W * DEPTH;
    localparam int FRAME_W = COUNT_W + BUF_W;
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

    typedef enum logic [1:0] {EMPTY, FILL, FULL_WAIT} acc_state_e;
    typedef enum logic       {SLOT_EMPTY, SLOT_VALID} slot_state_e;

    acc_state_e          acc_q, acc_d;
    slot_state_e         slot_q, slot_d;
    logic [BUF_W-1:0]    buf_q, buf_d, buf_acc;
    logic [COUNT_W-1:0]  cnt_q, cnt_d, cnt_acc;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                ovf_q, ovf_d;
    logic                slot_free, atom_en, accept, trigger, load;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        slot_free = (slot_q == SLOT_EMPTY) || frame_if.frame_ready;
        atom_en   = atom_valid && trace_enable;
        accept    = atom_en && (acc_q != FULL_WAIT);
        buf_acc   = accept ? {buf_q[BUF_W-ATOM_W-1:0], atom} : buf_q;
        cnt_acc   = accept ? cnt_q + COUNT_W'(1) : cnt_q;
        // A held FULL_WAIT buffer re-triggers every cycle via the count test.
        trigger   = (cnt_acc == FULL_CNT) || (flush && (cnt_acc != '0));
        load      = trigger && slot_free;

        acc_d   = acc_q;
        slot_d  = slot_q;
        buf_d   = buf_acc;
        cnt_d   = cnt_acc;
        frame_d = frame_q;

        if (load) begin
            frame_d = {cnt_acc, buf_acc};
            slot_d  = SLOT_VALID;
            buf_d   = '0;
            cnt_d   = '0;
            acc_d   = EMPTY;
        end else begin
            if (slot_q == SLOT_VALID && frame_if.frame_ready) slot_d = SLOT_EMPTY;
            if (cnt_acc == FULL_CNT)  acc_d = FULL_WAIT;
            else if (cnt_acc == '0)   acc_d = EMPTY;
            else                      acc_d = FILL;
        end

        // Setting wins over clearing when both happen together.
        if (atom_en && acc_q == FULL_WAIT) ovf_d = 1'b1;
        else if (overflow_clr)             ovf_d = 1'b0;
        else                               ovf_d = ovf_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= EMPTY;
            slot_q  <= SLOT_EMPTY;
            buf_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            slot_q  <= slot_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dct_buffer           = buf_q;
    assign dct_count            = cnt_q;
    assign overflow             = ovf_q;
    assign frame_if.frame_valid = (slot_q == SLOT_VALID);
    assign frame_if.frame_data  = frame_q;
endmodule

// File: tb/tb_cpu_ask2_nios2_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_cpu_ask2_nios2_oci_dct_packer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_enable, atom_valid, flush, overflow_clr;
    logic [1:0]  atom;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    cpu_ask2_nios2_oci_dct_packer_if #(.FRAME_W(34)) frame_if ();

    cpu_ask2_nios2_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_enable (trace_enable),
        .atom_valid   (atom_valid),
        .atom         (atom),
        .flush        (flush),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .frame_if     (frame_if.master)
    );

    always #5 clk = ~clk;

    // Reference model: accumulator as a queue of atoms, one-entry frame slot.
    int          q[$];
    bit          m_valid;
    logic [33:0] m_data;
    bit          m_ovf;
    bit          model_on = 1'b0;

    function automatic logic [29:0] pack_atoms();
        logic [29:0] b = '0;
        foreach (q[i]) b = (b << 2) | 30'(q[i]);
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step();
        bit en_atom, drop, free, want;
        en_atom = atom_valid && trace_enable;
        drop    = en_atom && (q.size() == 15);
        free    = !m_valid || frame_if.frame_ready;
        if (en_atom && !drop) q.push_back(int'(atom));
        want = (q.size() == 15) || (flush && q.size() > 0);
        if (m_valid && frame_if.frame_ready) m_valid = 1'b0;
        if (want && free) begin
            m_data  = {4'(q.size()), pack_atoms()};
            m_valid = 1'b1;
            q.delete();
        end
        if (drop) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] a, input logic f,
                         input logic en, input logic rdy, input logic clr);
        atom_valid           = v;
        atom                 = a;
        flush                = f;
        trace_enable         = en;
        frame_if.frame_ready = rdy;
        overflow_clr         = clr;
        @(posedge clk);
        if (model_on) model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle(0, 2'd0, 0, 1, 1, 0);
        cycle(0, 2'd0, 0, 1, 1, 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  a;
        logic        f;
        logic        en;
        logic [29:0] e_buf;
        logic [3:0]  e_cnt;
        logic        e_fv;
        logic [33:0] e_fd;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Atoms 1,2,3 then flush; atoms 0 x4 then atom 2 with flush; a disabled atom.
        vecs[0] = '{1'b1, 2'd1, 1'b0, 1'b1, 30'h1,  4'd1, 1'b0, 34'h0,          1'b0};
        vecs[1] = '{1'b1, 2'd2, 1'b0, 1'b1, 30'h6,  4'd2, 1'b0, 34'h0,          1'b0};
        vecs[2] = '{1'b1, 2'd3, 1'b0, 1'b1, 30'h1B, 4'd3, 1'b0, 34'h0,          1'b0};
        vecs[3] = '{1'b0, 2'd0, 1'b1, 1'b1, 30'h0,  4'd0, 1'b1, 34'h0_C000_001B, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 1'b0, 1'b1, 30'h0,  4'd1, 1'b0, 34'h0,          1'b0};
        vecs[5] = '{1'b1, 2'd0, 1'b0, 1'b1, 30'h0,  4'd2, 1'b0, 34'h0,          1'b0};
        vecs[6] = '{1'b1, 2'd0, 1'b0, 1'b1, 30'h0,  4'd3, 1'b0, 34'h0,          1'b0};
        vecs[7] = '{1'b1, 2'd0, 1'b0, 1'b1, 30'h0,  4'd4, 1'b0, 34'h0,          1'b0};
        vecs[8] = '{1'b1, 2'd2, 1'b1, 1'b1, 30'h0,  4'd0, 1'b1, 34'h1_4000_0002, 1'b0};
        vecs[9] = '{1'b1, 2'd3, 1'b0, 1'b0, 30'h0,  4'd0, 1'b0, 34'h0,          1'b0};

        reset_n = 1'b0;
        atom_valid = 0; atom = 0; flush = 0; trace_enable = 1;
        frame_if.frame_ready = 1; overflow_clr = 0;
        #12;
        check("reset_buffer", 64'(dct_buffer), 64'h0);
        check("reset_count",  64'(dct_count), 64'h0);
        check("reset_fvalid", 64'(frame_if.frame_valid), 64'h0);
        check("reset_fdata",  64'(frame_if.frame_data), 64'h0);
        check("reset_ovf",    64'(overflow), 64'h0);
        reset_n = 1'b1;
        cycle(0, 2'd0, 0, 1, 1, 0);

        // Table-driven directed vectors, frame_ready held high.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].v, vecs[i].a, vecs[i].f, vecs[i].en, 1'b1, 1'b0);
            check($sformatf("vec%0d_buffer", i), 64'(dct_buffer), 64'(vecs[i].e_buf));
            check($sformatf("vec%0d_count", i),  64'(dct_count), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d_fvalid", i), 64'(frame_if.frame_valid), 64'(vecs[i].e_fv));
            if (vecs[i].e_fv) check($sformatf("vec%0d_fdata", i), 64'(frame_if.frame_data), 64'(vecs[i].e_fd));
            check($sformatf("vec%0d_ovf", i),    64'(overflow), 64'(vecs[i].e_ovf));
        end

        // 15 atoms of 01 with ready high: frame emitted on the 15th edge.
        for (int i = 0; i < 15; i++) cycle(1, 2'b01, 0, 1, 1, 0);
        check("full15_fvalid", 64'(frame_if.frame_valid), 64'h1);
        check("full15_fdata",  64'(frame_if.frame_data), 64'h3_D555_5555);
        check("full15_count",  64'(dct_count), 64'h0);
        check("full15_ovf",    64'(overflow), 64'h0);
        cycle(0, 2'd0, 0, 1, 1, 0);

        // Blocked slot: 31 atoms, second buffer waits full, last atom dropped.
        for (int i = 0; i < 15; i++) cycle(1, 2'b11, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) cycle(1, 2'b10, 0, 1, 0, 0);
        check("wait_count_pre",  64'(dct_count), 64'd15);
        check("wait_ovf_pre",    64'(overflow), 64'h0);
        cycle(1, 2'b01, 0, 1, 0, 0);
        check("wait_fdata_held", 64'(frame_if.frame_data), 64'h3_FFFF_FFFF);
        check("wait_fvalid",     64'(frame_if.frame_valid), 64'h1);
        check("wait_count",      64'(dct_count), 64'd15);
        check("wait_buffer",     64'(dct_buffer), 64'h2AAA_AAAA);
        check("wait_ovf",        64'(overflow), 64'h1);
        cycle(0, 2'd0, 0, 1, 1, 0);
        check("xfer_count",  64'(dct_count), 64'h0);
        check("xfer_fvalid", 64'(frame_if.frame_valid), 64'h1);
        check("xfer_fdata",  64'(frame_if.frame_data), 64'h3_EAAA_AAAA);
        cycle(0, 2'd0, 0, 1, 0, 1);
        check("ovf_clear", 64'(overflow), 64'h0);

        // trace_enable low ignores atoms; then drop + clear keeps overflow set.
        for (int i = 0; i < 3; i++) cycle(1, 2'b01, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 2'b11, 0, 0, 0, 0);
        check("disabled_count",  64'(dct_count), 64'd3);
        check("disabled_buffer", 64'(dct_buffer), 64'h15);
        check("disabled_ovf",    64'(overflow), 64'h0);
        for (int i = 0; i < 12; i++) cycle(1, 2'b01, 0, 1, 0, 0);
        cycle(1, 2'b10, 0, 1, 0, 1);
        check("drop_clr_ovf",   64'(overflow), 64'h1);
        check("drop_clr_count", 64'(dct_count), 64'd15);

        // Asynchronous reset at count 9 with a pending frame.
        cycle(0, 2'd0, 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) cycle(1, 2'b10, 0, 1, 0, 0);
        check("pre_rst_count",  64'(dct_count), 64'd9);
        check("pre_rst_fvalid", 64'(frame_if.frame_valid), 64'h1);
        reset_n = 1'b0;
        #2;
        check("async_rst_buffer", 64'(dct_buffer), 64'h0);
        check("async_rst_count",  64'(dct_count), 64'h0);
        check("async_rst_fvalid", 64'(frame_if.frame_valid), 64'h0);
        check("async_rst_fdata",  64'(frame_if.frame_data), 64'h0);
        check("async_rst_ovf",    64'(overflow), 64'h0);
        reset_n = 1'b1;
        cycle(1, 2'b11, 0, 1, 0, 0);
        check("post_rst_buffer", 64'(dct_buffer), 64'h3);
        check("post_rst_count",  64'(dct_count), 64'd1);

        // Random traffic against the reference model.
        do_reset();
        model_on = 1'b1;
        begin
            int ready_mode = 0;
            for (int n = 0; n < 2500; n++) begin
                logic rdy;
                if (n % 64 == 0) ready_mode = int'($urandom_range(0, 2));
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = ($urandom_range(0, 7) == 0);
                endcase
                cycle($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0,
                      rdy, $urandom_range(0, 19) == 0);
                check("rnd_buffer", 64'(dct_buffer), 64'(pack_atoms()));
                check("rnd_count",  64'(dct_count), 64'(q.size()));
                check("rnd_fvalid", 64'(frame_if.frame_valid), 64'(m_valid));
                if (m_valid) check("rnd_fdata", 64'(frame_if.frame_data), 64'(m_data));
                check("rnd_ovf",    64'(overflow), 64'(m_ovf));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
